// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, start/busy/done handshake.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module mdu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [2:0]          r_op;
  logic                r_sa;
  logic                r_sb;
  logic                r_special;
  logic [XLEN-1:0]     r_spec_val;
  logic [CW-1:0]       r_cnt;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_opnd;
  logic                r_busy;
  logic                r_done;
  logic [XLEN-1:0]     r_result;

  logic                w_is_div;
  logic                w_a_signed;
  logic                w_b_signed;
  logic                w_sa;
  logic                w_sb;
  logic [XLEN-1:0]     w_a_mag;
  logic [XLEN-1:0]     w_b_mag;
  logic                w_div_zero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_spec_val;
  logic                w_accept;

  logic [XLEN:0]       w_mul_sum;
  logic [2*XLEN-1:0]   w_mul_next;
  logic [XLEN:0]       w_div_sh;
  logic [XLEN:0]       w_div_diff;
  logic [2*XLEN-1:0]   w_div_next;

  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_fin;

  // Operand decode at the accept edge
  always_comb begin
    w_is_div   = funct3[2];
    w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                 (funct3 == 3'b100) || (funct3 == 3'b110);
    w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    w_sa       = w_a_signed & a[XLEN-1];
    w_sb       = w_b_signed & b[XLEN-1];
    w_a_mag    = w_sa ? -a : a;
    w_b_mag    = w_sb ? -b : b;
    w_div_zero = w_is_div && (b == '0);
    w_ovf      = w_is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    w_special  = w_div_zero || w_ovf;
    w_spec_val = '0;
    if (w_div_zero) begin
      w_spec_val = funct3[1] ? a : '1;
    end else if (w_ovf) begin
      w_spec_val = funct3[1] ? '0 : a;
    end
    w_accept   = (r_state == StIdle) && start && !flush;
  end

  // One iteration step for each algorithm
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opnd};
    w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
    // Partial remainder shifted left with the next dividend bit appended
    w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
    w_div_diff = w_div_sh - {1'b0, r_opnd};
    if (w_div_diff[XLEN]) begin
      w_div_next = {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
    end else begin
      w_div_next = {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
    end
  end

  // Sign fix-up and result selection in FIN
  always_comb begin
    w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
    w_quot = r_acc[XLEN-1:0];
    w_rem  = r_acc[2*XLEN-1:XLEN];
    w_fin  = '0;
    if (r_special) begin
      w_fin = r_spec_val;
    end else begin
      unique case (r_op)
        3'b000:                 w_fin = w_prod[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fin = w_prod[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_fin = (r_sa ^ r_sb) ? -w_quot : w_quot;
        3'b110, 3'b111:         w_fin = r_sa ? -w_rem : w_rem;
        default:                w_fin = '0;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = w_special ? StFin : StCalc;
        end
      end
      StCalc: begin
        if (flush) begin
          w_state_nxt = StIdle;
        end else if (r_cnt == CW'(1)) begin
          w_state_nxt = StFin;
        end
      end
      StFin: begin
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_op       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_special  <= 1'b0;
      r_spec_val <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_opnd     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != StIdle);
      r_done  <= (r_state == StFin) && !flush;
      if ((r_state == StFin) && !flush) begin
        r_result <= w_fin;
      end
      if (w_accept) begin
        r_op       <= funct3;
        r_sa       <= w_sa;
        r_sb       <= w_sb;
        r_special  <= w_special;
        r_spec_val <= w_spec_val;
        r_cnt      <= CW'(XLEN);
        // Multiply: low half holds the multiplier; divide: low half holds the dividend
        r_acc      <= {{XLEN{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
        r_opnd     <= w_is_div ? w_b_mag : w_a_mag;
      end else if (r_state == StCalc) begin
        if (flush) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt - CW'(1);
          r_acc <= r_op[2] ? w_div_next : w_mul_next;
        end
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised iterative multiply/divide unit for the Execute stage of the pipelined RV32 datapath. It adds the RV32M/RV64M operation set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) at one bit per cycle, with a start/busy/done handshake. The hazard unit stalls F/D/E while `busy` is high. The block receives forwarded operands (SrcAE and the forwarded rs2 value) and returns a registered result, which is muxed in place of ALUResultE.

## Interface
- `XLEN`, default 32: operand and result width; must be ≥ 4 and even.
- `clk  in  1`: rising-edge clock.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: operation request; sampled only in IDLE.
- `funct3  in  3`: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a  in  XLEN`: rs1 operand (dividend / multiplicand).
- `b  in  XLEN`: rs2 operand (divisor / multiplier).
- `flush  in  1`: synchronous kill of the operation in flight (driven from FlushE).
- `busy  out  1`: registered; high while an operation is in progress.
- `done  out  1`: registered; one-cycle pulse, result valid.
- `result  out  XLEN`: registered; holds its value until the next `done`.

## Operation
- States:
  - IDLE: `busy` = 0.
  - CALC: iterating.
  - FIN: sign fix and output.
- Accept: when IDLE, `start` = 1 and `flush` = 0 at an edge, the block latches `funct3`, the operand magnitudes and the sign flags, and sets `busy` = 1.
- Signedness:
  - Signed operand for `a`: MULH, MULHSU, DIV, REM.
  - Signed operand for `b`: MULH, DIV, REM.
  - All other operands are unsigned.
  - A negative signed operand is replaced by its two's-complement magnitude.
- Multiply:
  - Shift-add over a 2·XLEN accumulator, one multiplier bit per CALC cycle, XLEN cycles.
  - Product sign = sa ^ sb.
  - Negation is applied to the full 2·XLEN product in FIN.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring division, one quotient bit per CALC cycle, XLEN cycles.
  - Quotient sign = sa ^ sb; remainder sign = sa.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases bypass CALC and go straight to FIN:
  - Divide by zero: DIV and DIVU return all-ones; REM and REMU return `a`.
  - Signed overflow (DIV/REM with `a` = 2^(XLEN−1) and `b` = −1): DIV returns `a`; REM returns 0.
- An iteration counter of width log2(XLEN)+1 counts down from XLEN. CALC→FIN on the cycle the counter reaches 0.
- FIN registers `result`, pulses `done` and returns to IDLE. `busy` falls on that same edge.
- `start` while `busy` = 1 is ignored; no queueing.
- `flush` = 1 at an edge in CALC or FIN: next state IDLE, `busy` = 0, no `done`, `result` unchanged. In IDLE, flush overrides a coincident `start`.
- Reset (asynchronous, any time, including mid-operation): state IDLE, `busy` = 0, `done` = 0, `result` = 0, counter = 0, accumulators = 0.

## Timing
- Start accepted at edge k:
  - `busy` = 1 from edge k.
  - CALC iterations occur on edges k+1 … k+XLEN.
  - FIN: `done` = 1 and `result` valid from edge k+XLEN+1, for exactly one cycle; `busy` = 0 in that same cycle.
  - Total latency is XLEN+1 edges; 33 for XLEN = 32.
- Special case accepted at edge k: `done` and `result` valid from edge k+1.
- Back-to-back operation: `start` may be high in the `done` cycle; it is accepted at the next edge, so there are no idle bubbles.
- Operands `a`, `b` and `funct3` are needed only at the accept edge; later changes have no effect.
- `done` never rises in a cycle following a flush edge for the killed operation.

## Test plan
- MUL, `a` = 7, `b` = 0xFFFFFFFD (−3), start at edge k → `busy` 1 at k..k+32, `done` pulse at k+33, `result` = 0xFFFFFFEB.
- `a` = 0xFFFFFFFF, `b` = 0xFFFFFFFF for each high-product op:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
  - MUL → 0x00000001.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each after 33 edges. Back-to-back issue in the `done` cycles yields no gaps.
- Special cases, each with `done` one edge after start:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- DIVU started, `flush` at iteration 10 → `busy` 0 at the next edge, no `done`, `result` keeps its previous value. A new MUL 3×4 issued next cycle → 12 after 33 edges.
- `rst` asserted low mid-CALC, asynchronously between edges → `busy`, `done` and `result` go to 0 immediately. After release, `start` pulses while busy are ignored: exactly one `done` per accepted start.
